// File: rtl/serial_pkg.sv
// Shared line-level constants and FSM state type for the serial frame link.
// The downstream receiver imports the same definitions.
package serial_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} serial_state_e;

  localparam logic IDLE_LEVEL  = 1'b0;
  localparam logic START_LEVEL = 1'b1;
  localparam logic STOP_LEVEL  = 1'b0;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-time generator: tick pulses on the last clock of each CLKS_PER_BIT period.
// clear restarts the period so every FSM state begins on a fresh bit time.
module bit_tick_gen #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Framed parallel-to-serial transmitter: start, LSB-first data, optional parity, stop.
// A one-word holding register lets the next frame follow the current one without a gap.
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             x_o,
  output logic             busy_o,
  output logic             frame_done_o
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  serial_state_e    state, state_next;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic [WIDTH-1:0] shifter, shifter_next;
  logic [IW-1:0]    bit_idx;
  logic             parity_bit;
  logic             tick, clear, load, accept, x_next;

  function automatic logic frame_parity(input logic [WIDTH-1:0] w);
    return (^w) ^ PARITY_ODD;
  endfunction

  assign accept       = valid_i && !hold_full;
  assign ready_o      = !hold_full;
  assign busy_o       = (state != IDLE);
  assign frame_done_o = (state == STOP) && tick;
  assign clear        = (state_next != state) || (state == IDLE);

  bit_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .tick    (tick)
  );

  always_comb begin
    state_next   = state;
    shifter_next = shifter;
    x_next       = IDLE_LEVEL;
    load         = 1'b0;
    case (state)
      IDLE:    if (hold_full) state_next = START;
      START:   if (tick) state_next = DATA;
      DATA:    if (tick && (bit_idx == LAST_IDX)) state_next = PARITY_EN ? PARITY : STOP;
      PARITY:  if (tick) state_next = STOP;
      STOP:    if (tick) state_next = hold_full ? START : IDLE;
      default: state_next = IDLE;
    endcase
    load = (state_next == START) && (state != START);
    if (load) begin
      shifter_next = hold_data;
    end else if ((state == DATA) && tick) begin
      shifter_next = shifter >> 1;
    end
    // x_o is registered, so it is driven from the level of the state being entered
    case (state_next)
      START:   x_next = START_LEVEL;
      DATA:    x_next = shifter_next[0];
      PARITY:  x_next = parity_bit;
      STOP:    x_next = STOP_LEVEL;
      default: x_next = IDLE_LEVEL;
    endcase
  end

  // control stage: state, hold occupancy, bit index, line register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      bit_idx   <= '0;
      x_o       <= IDLE_LEVEL;
    end else begin
      state <= state_next;
      x_o   <= x_next;
      if (accept) begin
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (state != DATA) begin
        bit_idx <= '0;
      end else if (tick) begin
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // data stage: word storage needs no reset, hold_full/state qualify it
  always_ff @(posedge clk) begin
    shifter <= shifter_next;
    if (accept) hold_data <= data_i;
    if (load) parity_bit <= frame_parity(hold_data);
  end

endmodule
